// File: rtl/instr_sequencer.sv
// instr_sequencer: programmable instruction stream source for mydatapath.
//
// A DEPTH x 25 program memory is loaded through prog_we/prog_addr/prog_wdata while the
// sequencer is not busy. Word format: {halt[24], function_code[23:16], data[15:0]}.
// On start (in IDLE, without stop) words are issued from address 0, each held for HOLD
// cycles, back to back, until a halt-marked word or the last address has been issued.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   prog_we/addr/wdata    program-memory write port (ignored while busy)
//   start, stop           begin execution at address 0 / abort execution
//   data, function_code   registered instruction fields to the datapath
//   pc                    address of the word currently presented
//   step_strobe           high in the first cycle of each new word
//   busy                  high while running
//   done                  one-cycle pulse on normal completion
//
// Optional feature: define SEQ_SINGLE_STEP_EN to add step_mode/step inputs. With
// step_mode=1 the sequencer parks on the current word once its hold time has elapsed and
// moves on only in a cycle where step=1.
module instr_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned HOLD  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [24:0]   prog_wdata,
  input  logic          start,
  input  logic          stop,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          step_mode,
  input  logic          step,
`endif
  output logic [15:0]   data,
  output logic [7:0]    function_code,
  output logic [AW-1:0] pc,
  output logic          step_strobe,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pc_q, pc_d, pc_nxt;
  logic [15:0]   data_q, data_d;
  logic [7:0]    fc_q, fc_d;
  logic          strobe_q, strobe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [24:0]   mem_q [DEPTH];

  logic hold_done, last_word, hold_here;

  // Program memory has no reset: contents survive reset and repeated runs.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_q) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  assign pc_nxt    = pc_q + AW'(1);
  assign hold_done = (cnt_q == CW'(HOLD - 1));
  // pc never wraps: the last address ends the program even without a halt bit.
  assign last_word = mem_q[pc_q][24] || (pc_q == AW'(DEPTH - 1));

`ifdef SEQ_SINGLE_STEP_EN
  assign hold_here = step_mode && !step;
`else
  assign hold_here = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    data_d   = data_q;
    fc_d     = fc_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        data_d = '0;
        fc_d   = '0;
        busy_d = 1'b0;
        if (start && !stop) begin
          state_d  = StRun;
          pc_d     = '0;
          cnt_d    = '0;
          data_d   = mem_q[0][15:0];
          fc_d     = mem_q[0][23:16];
          strobe_d = 1'b1;
          busy_d   = 1'b1;
        end
      end

      StRun: begin
        if (stop) begin
          state_d = StIdle;
          pc_d    = '0;
          cnt_d   = '0;
          data_d  = '0;
          fc_d    = '0;
          busy_d  = 1'b0;
        end else if (!hold_done) begin
          cnt_d = cnt_q + CW'(1);
        end else if (hold_here) begin
          // Parked on the current word: outputs, pc and counter all hold.
          cnt_d = cnt_q;
        end else if (last_word) begin
          state_d = StDone;
          cnt_d   = '0;
          data_d  = '0;
          fc_d    = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          pc_d     = pc_nxt;
          cnt_d    = '0;
          data_d   = mem_q[pc_nxt][15:0];
          fc_d     = mem_q[pc_nxt][23:16];
          strobe_d = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
        data_d  = '0;
        fc_d    = '0;
        busy_d  = 1'b0;
        if (stop) begin
          pc_d = '0;
        end
      end

      default: begin
        state_d = StIdle;
        data_d  = '0;
        fc_d    = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pc_q     <= '0;
      data_q   <= '0;
      fc_q     <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      data_q   <= data_d;
      fc_q     <= fc_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign data          = data_q;
  assign function_code = fc_q;
  assign pc            = pc_q;
  assign step_strobe   = strobe_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer. Two instances share one stimulus stream: instance 0 with
// HOLD=3 and instance 1 with HOLD=1. A run-level model (time since start divided by HOLD
// selects the word) predicts every output each cycle; directed literal checks pin it.
module tb_instr_sequencer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [24:0]   prog_wdata = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
`endif

  logic [15:0]   data_o [2];
  logic [7:0]    fc_o [2];
  logic [AW-1:0] pc_o [2];
  logic          strobe_o [2];
  logic          busy_o [2];
  logic          done_o [2];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .HOLD(3)) u_dut0 (
    .clk           (clk),
    .reset         (reset),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_wdata    (prog_wdata),
    .start         (start),
    .stop          (stop),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode     (step_mode),
    .step          (step),
`endif
    .data          (data_o[0]),
    .function_code (fc_o[0]),
    .pc            (pc_o[0]),
    .step_strobe   (strobe_o[0]),
    .busy          (busy_o[0]),
    .done          (done_o[0])
  );

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .HOLD(1)) u_dut1 (
    .clk           (clk),
    .reset         (reset),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_wdata    (prog_wdata),
    .start         (start),
    .stop          (stop),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode     (step_mode),
    .step          (step),
`endif
    .data          (data_o[1]),
    .function_code (fc_o[1]),
    .pc            (pc_o[1]),
    .step_strobe   (strobe_o[1]),
    .busy          (busy_o[1]),
    .done          (done_o[1])
  );

  // ---------------- model ----------------
  logic [24:0]   mmem [2][DEPTH];
  bit            m_run [2] = '{1'b0, 1'b0};
  bit            m_dn [2] = '{1'b0, 1'b0};
  int            m_t [2] = '{0, 0};
  int            m_n [2] = '{0, 0};
  logic [AW-1:0] m_pcidle [2] = '{'0, '0};

  function automatic int hold_of(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  // Number of words a run will issue: up to and including the first halt word.
  function automatic int prog_len(input int i);
    for (int k = 0; k < DEPTH; k++) begin
      if (mmem[i][k][24]) return k + 1;
    end
    return DEPTH;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_run[i]    <= 1'b0;
        m_dn[i]     <= 1'b0;
        m_t[i]      <= 0;
        m_pcidle[i] <= '0;
      end else begin
        if (prog_we && !m_run[i]) mmem[i][prog_addr] <= prog_wdata;
        if (m_run[i]) begin
          if (stop) begin
            m_run[i]    <= 1'b0;
            m_pcidle[i] <= '0;
          end else if (m_t[i] + 1 == m_n[i] * hold_of(i)) begin
            m_run[i]    <= 1'b0;
            m_dn[i]     <= 1'b1;
            m_pcidle[i] <= AW'(m_n[i] - 1);
          end else begin
            m_t[i] <= m_t[i] + 1;
          end
        end else if (m_dn[i]) begin
          m_dn[i] <= 1'b0;
          if (stop) m_pcidle[i] <= '0;
        end else if (start && !stop) begin
          m_run[i] <= 1'b1;
          m_t[i]   <= 0;
          m_n[i]   <= prog_len(i);
        end
      end
    end
  end

  task automatic expect_out(input int i, output logic [15:0] d, output logic [7:0] f,
                            output logic [AW-1:0] p, output logic s, output logic b,
                            output logic dn);
    int k;
    d  = '0;
    f  = '0;
    p  = m_pcidle[i];
    s  = 1'b0;
    b  = 1'b0;
    dn = m_dn[i];
    if (m_run[i]) begin
      k = m_t[i] / hold_of(i);
      d = mmem[i][k][15:0];
      f = mmem[i][k][23:16];
      p = AW'(k);
      s = (m_t[i] % hold_of(i)) == 0;
      b = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0]   ed;
    logic [7:0]    ef;
    logic [AW-1:0] ep;
    logic          es, eb, edn;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        expect_out(i, ed, ef, ep, es, eb, edn);
        check($sformatf("m%0d.data", i), 32'(data_o[i]), 32'(ed));
        check($sformatf("m%0d.fc", i), 32'(fc_o[i]), 32'(ef));
        check($sformatf("m%0d.pc", i), 32'(pc_o[i]), 32'(ep));
        check($sformatf("m%0d.strobe", i), 32'(strobe_o[i]), 32'(es));
        check($sformatf("m%0d.busy", i), 32'(busy_o[i]), 32'(eb));
        check($sformatf("m%0d.done", i), 32'(done_o[i]), 32'(edn));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_word(input int a, input logic [24:0] w);
    prog_we    = 1'b1;
    prog_addr  = AW'(a);
    prog_wdata = w;
    tick();
    prog_we    = 1'b0;
  endtask

  task automatic run_p1();
    start = 1'b1;
    for (int j = 1; j <= 22; j++) begin
      tick();
      if (j == 1) start = 1'b0;
      case (j)
        1: begin
          check("p1.w0.data", 32'(data_o[0]), 32'h0001);
          check("p1.w0.strobe", 32'(strobe_o[0]), 32'h1);
          check("p1.w0.busy", 32'(busy_o[0]), 32'h1);
        end
        3: check("p1.w0.hold.strobe", 32'(strobe_o[0]), 32'h0);
        4: begin
          check("p1.w1.data", 32'(data_o[0]), 32'h0020);
          check("p1.w1.fc", 32'(fc_o[0]), 32'h20);
        end
        7: check("p1.w2.fc", 32'(fc_o[0]), 32'hA0);
        6: begin
          check("p1.h1.w5.data", 32'(data_o[1]), 32'h0100);
          check("p1.h1.w5.pc", 32'(pc_o[1]), 32'h5);
        end
        16: begin
          check("p1.w5.data", 32'(data_o[0]), 32'h0100);
          check("p1.w5.strobe", 32'(strobe_o[0]), 32'h1);
        end
        18: check("p1.w5.last.data", 32'(data_o[0]), 32'h0100);
        19: begin
          check("p1.done", 32'(done_o[0]), 32'h1);
          check("p1.done.data", 32'(data_o[0]), 32'h0);
          check("p1.done.busy", 32'(busy_o[0]), 32'h0);
        end
        20: check("p1.done.pulse", 32'(done_o[0]), 32'h0);
        default: ;
      endcase
      if (j == 7) check("p1.h1.done", 32'(done_o[1]), 32'h1);
    end
  endtask

  initial begin
    logic [24:0] p1 [6];
    p1 = '{25'h0000001, 25'h0200020, 25'h0A00000, 25'h0A00000, 25'h0A00000, 25'h1200100};

    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst.data", 32'(data_o[0]), 32'h0);
    check("rst.busy", 32'(busy_o[0]), 32'h0);
    check("rst.pc", 32'(pc_o[1]), 32'h0);
    repeat (5) tick();
    check("idle.done", 32'(done_o[0]), 32'h0);

    for (int k = 0; k < DEPTH; k++) begin
      write_word(k, (k < 6) ? p1[k] : {1'b0, 8'h0F, 16'(k)});
    end

    // stop wins over start in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    check("startstop.busy0", 32'(busy_o[0]), 32'h0);
    check("startstop.busy1", 32'(busy_o[1]), 32'h0);

    run_p1();
    run_p1();

    // 16 words, no halt bits
    for (int k = 0; k < DEPTH; k++) write_word(k, {1'b0, 8'(8'h30 + k), 16'(16'h1000 + k)});
    start = 1'b1;
    for (int j = 1; j <= 52; j++) begin
      tick();
      if (j == 1) start = 1'b0;
      if (j == 16) begin
        check("p2.h1.pc15", 32'(pc_o[1]), 32'hF);
        check("p2.h1.data15", 32'(data_o[1]), 32'h100F);
      end
      if (j == 17) begin
        check("p2.h1.done", 32'(done_o[1]), 32'h1);
        check("p2.h1.done.data", 32'(data_o[1]), 32'h0);
      end
      if (j == 46) check("p2.h3.pc15", 32'(pc_o[0]), 32'hF);
      if (j == 49) check("p2.h3.done", 32'(done_o[0]), 32'h1);
    end

    // stop mid-run plus an ignored write
    start = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      tick();
      if (j == 1) start = 1'b0;
      if (j == 5) begin
        prog_we    = 1'b1;
        prog_addr  = AW'(1);
        prog_wdata = 25'h1FFFFFF;
      end
      if (j == 6) prog_we = 1'b0;
      if (j == 8) begin
        check("stop.pc2", 32'(pc_o[0]), 32'h2);
        stop = 1'b1;
      end
      if (j == 9) begin
        stop = 1'b0;
        check("stop.busy", 32'(busy_o[0]), 32'h0);
        check("stop.data", 32'(data_o[0]), 32'h0);
        check("stop.pc", 32'(pc_o[0]), 32'h0);
        check("stop.h1.busy", 32'(busy_o[1]), 32'h0);
      end
      if (j > 9) check("stop.nodone", 32'(done_o[0]), 32'h0);
    end
    start = 1'b1;
    for (int j = 1; j <= 52; j++) begin
      tick();
      if (j == 1) start = 1'b0;
      if (j == 2) check("readback.h1", 32'(data_o[1]), 32'h1001);
      if (j == 4) begin
        check("readback.h3", 32'(data_o[0]), 32'h1001);
        check("readback.h3.fc", 32'(fc_o[0]), 32'h31);
      end
    end

    // reset mid-run while instance 0's hold counter is 1
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst.data", 32'(data_o[0]), 32'h0);
    check("midrst.pc", 32'(pc_o[0]), 32'h0);
    check("midrst.busy", 32'(busy_o[0]), 32'h0);
    check("midrst.strobe", 32'(strobe_o[0]), 32'h0);
    repeat (3) tick();

`ifdef SEQ_SINGLE_STEP_EN
    chk_en    = 1'b0;
    step_mode = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("step%0d.held.pc", i), 32'(pc_o[i]), 32'h0);
      check($sformatf("step%0d.held.data", i), 32'(data_o[i]), 32'h1000);
      check($sformatf("step%0d.held.busy", i), 32'(busy_o[i]), 32'h1);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("step%0d.adv.pc", i), 32'(pc_o[i]), 32'h1);
      check($sformatf("step%0d.adv.data", i), 32'(data_o[i]), 32'h1001);
      check($sformatf("step%0d.adv.strobe", i), 32'(strobe_o[i]), 32'h1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    step_mode = 1'b0;
    tick();
    chk_en = 1'b1;
    repeat (3) tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
